// File: rtl/pool_pkg.sv
// Shared types and constants for the pooling-engine control sequencer.
package pool_pkg;

  localparam int DIM_W_DEF  = 16;
  localparam int ADDR_W_DEF = 16;

  localparam logic [DIM_W_DEF-1:0] POOL_MAX = 16'd0;
  localparam logic [DIM_W_DEF-1:0] POOL_AVG = 16'd1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_CALC_W = 3'd2,
    ST_CALC_H = 3'd3,
    ST_RUN    = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_DONE   = 3'd6
  } pool_state_e;

endpackage

// File: rtl/pool_addr_gen.sv
// Five-level window walker (c, oy, ox, ky, kx) producing input-buffer
// addresses from incremental base registers, plus first/last-of-window flags.
// All outputs are registered; counters move only on step, restart on load.
module pool_addr_gen
  import pool_pkg::*;
#(
  parameter int DIM_W  = DIM_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DIM_W-1:0]  data_wid,
  input  logic [DIM_W-1:0]  pool_horiz,
  input  logic [DIM_W-1:0]  pool_vert,
  input  logic [DIM_W-1:0]  horiz_stride,
  input  logic [DIM_W-1:0]  out_wid,
  input  logic [DIM_W-1:0]  out_hei,
  input  logic [DIM_W-1:0]  out_ch,
  input  logic [ADDR_W-1:0] plane,
  input  logic [ADDR_W-1:0] row_step,
  output logic [ADDR_W-1:0] addr,
  output logic              first,
  output logic              last,
  output logic              last_elem
);

  logic [DIM_W-1:0]  kx_r, ky_r, ox_r, oy_r, c_r;
  logic [ADDR_W-1:0] ch_base_r, line_base_r, win_base_r, row_base_r;

  logic [DIM_W-1:0]  nxt_kx_s, nxt_ky_s, nxt_ox_s, nxt_oy_s, nxt_c_s;
  logic [ADDR_W-1:0] nxt_ch_base_s, nxt_line_base_s, nxt_win_base_s, nxt_row_base_s, nxt_addr_s;
  logic [DIM_W-1:0]  ph_m1_s, pv_m1_s, ow_m1_s, oh_m1_s, oc_m1_s;
  logic [ADDR_W-1:0] wid_inc_s, hstr_inc_s;
  logic              first_s, last_s, last_elem_s;

  // Next-counter and next-address computation: innermost loop first, carries ripple outward.
  always_comb begin
    ph_m1_s    = pool_horiz - DIM_W'(1'b1);
    pv_m1_s    = pool_vert - DIM_W'(1'b1);
    ow_m1_s    = out_wid - DIM_W'(1'b1);
    oh_m1_s    = out_hei - DIM_W'(1'b1);
    oc_m1_s    = out_ch - DIM_W'(1'b1);
    wid_inc_s  = ADDR_W'(data_wid);
    hstr_inc_s = ADDR_W'(horiz_stride);

    nxt_kx_s        = kx_r;
    nxt_ky_s        = ky_r;
    nxt_ox_s        = ox_r;
    nxt_oy_s        = oy_r;
    nxt_c_s         = c_r;
    nxt_ch_base_s   = ch_base_r;
    nxt_line_base_s = line_base_r;
    nxt_win_base_s  = win_base_r;
    nxt_row_base_s  = row_base_r;
    nxt_addr_s      = addr;

    if (load) begin
      nxt_kx_s        = '0;
      nxt_ky_s        = '0;
      nxt_ox_s        = '0;
      nxt_oy_s        = '0;
      nxt_c_s         = '0;
      nxt_ch_base_s   = '0;
      nxt_line_base_s = '0;
      nxt_win_base_s  = '0;
      nxt_row_base_s  = '0;
      nxt_addr_s      = '0;
    end else if (step) begin
      if (kx_r != ph_m1_s) begin
        nxt_kx_s   = kx_r + DIM_W'(1'b1);
        nxt_addr_s = addr + ADDR_W'(1'b1);
      end else if (ky_r != pv_m1_s) begin
        nxt_kx_s       = '0;
        nxt_ky_s       = ky_r + DIM_W'(1'b1);
        nxt_row_base_s = row_base_r + wid_inc_s;
        nxt_addr_s     = row_base_r + wid_inc_s;
      end else if (ox_r != ow_m1_s) begin
        nxt_kx_s       = '0;
        nxt_ky_s       = '0;
        nxt_ox_s       = ox_r + DIM_W'(1'b1);
        nxt_win_base_s = win_base_r + hstr_inc_s;
        nxt_row_base_s = win_base_r + hstr_inc_s;
        nxt_addr_s     = win_base_r + hstr_inc_s;
      end else if (oy_r != oh_m1_s) begin
        nxt_kx_s        = '0;
        nxt_ky_s        = '0;
        nxt_ox_s        = '0;
        nxt_oy_s        = oy_r + DIM_W'(1'b1);
        nxt_line_base_s = line_base_r + row_step;
        nxt_win_base_s  = line_base_r + row_step;
        nxt_row_base_s  = line_base_r + row_step;
        nxt_addr_s      = line_base_r + row_step;
      end else if (c_r != oc_m1_s) begin
        nxt_kx_s        = '0;
        nxt_ky_s        = '0;
        nxt_ox_s        = '0;
        nxt_oy_s        = '0;
        nxt_c_s         = c_r + DIM_W'(1'b1);
        nxt_ch_base_s   = ch_base_r + plane;
        nxt_line_base_s = ch_base_r + plane;
        nxt_win_base_s  = ch_base_r + plane;
        nxt_row_base_s  = ch_base_r + plane;
        nxt_addr_s      = ch_base_r + plane;
      end else begin
        // final element already issued; the FSM leaves RUN on this handshake
        nxt_addr_s = addr;
      end
    end else begin
      nxt_addr_s = addr;
    end

    first_s     = (nxt_kx_s == '0) && (nxt_ky_s == '0);
    last_s      = (nxt_kx_s == ph_m1_s) && (nxt_ky_s == pv_m1_s);
    last_elem_s = last_s && (nxt_ox_s == ow_m1_s) && (nxt_oy_s == oh_m1_s) && (nxt_c_s == oc_m1_s);
  end

  // Counter, base and flag registers; flags are precomputed from the next counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      kx_r        <= '0;
      ky_r        <= '0;
      ox_r        <= '0;
      oy_r        <= '0;
      c_r         <= '0;
      ch_base_r   <= '0;
      line_base_r <= '0;
      win_base_r  <= '0;
      row_base_r  <= '0;
      addr        <= '0;
      first       <= 1'b0;
      last        <= 1'b0;
      last_elem   <= 1'b0;
    end else if (load || step) begin
      kx_r        <= nxt_kx_s;
      ky_r        <= nxt_ky_s;
      ox_r        <= nxt_ox_s;
      oy_r        <= nxt_oy_s;
      c_r         <= nxt_c_s;
      ch_base_r   <= nxt_ch_base_s;
      line_base_r <= nxt_line_base_s;
      win_base_r  <= nxt_win_base_s;
      row_base_r  <= nxt_row_base_s;
      addr        <= nxt_addr_s;
      first       <= first_s;
      last        <= last_s;
      last_elem   <= last_elem_s;
    end else begin
      addr <= addr;
    end
  end

endmodule

// File: rtl/pool_sequencer.sv
// Pooling-engine control sequencer: latches and validates the configuration,
// derives output dimensions by iterative stepping, walks all pooling windows
// through pool_addr_gen, then waits for the datapath to drain.
module pool_sequencer
  import pool_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIM_W  = DIM_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_data_wid,
  input  logic [DIM_W-1:0]  cfg_data_hei,
  input  logic [DIM_W-1:0]  cfg_data_ch,
  input  logic [DIM_W-1:0]  cfg_pool_type,
  input  logic [DIM_W-1:0]  cfg_pool_horiz,
  input  logic [DIM_W-1:0]  cfg_pool_vert,
  input  logic [DIM_W-1:0]  cfg_horiz_stride,
  input  logic [DIM_W-1:0]  cfg_vert_stride,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              win_first,
  output logic              win_last,
  output logic              dp_op,
  output logic [DIM_W-1:0]  win_size,
  input  logic              dp_idle,
  output logic [DIM_W-1:0]  output_wid,
  output logic [DIM_W-1:0]  output_hei,
  output logic [DIM_W-1:0]  output_ch,
  output logic [DIM_W-1:0]  out_data_wid,
  output logic [DIM_W-1:0]  out_data_hei,
  output logic              busy,
  output logic              done,
  output logic              err
);

  pool_state_e       state_r;
  logic [DIM_W-1:0]  data_wid_r, data_hei_r, data_ch_r, pool_type_r;
  logic [DIM_W-1:0]  pool_horiz_r, pool_vert_r, hstride_r, vstride_r;
  logic [ADDR_W-1:0] plane_r, row_step_r;
  logic [DIM_W:0]    pos_w_r, pos_h_r;

  logic [ADDR_W-1:0] plane_s, row_step_s;
  logic [DIM_W-1:0]  win_size_s;
  logic [DIM_W:0]    pos_w_init_s, pos_h_init_s;
  logic              cfg_bad_s, calc_w_go_s, calc_h_go_s, load_s, step_s, last_elem_s;

  assign out_data_wid = output_wid;
  assign out_data_hei = output_hei;

  // Config validation, one-time products and the "window still fits" tests for dimension stepping.
  always_comb begin
    plane_s      = ADDR_W'(data_wid_r) * ADDR_W'(data_hei_r);
    row_step_s   = ADDR_W'(vstride_r) * ADDR_W'(data_wid_r);
    win_size_s   = pool_horiz_r * pool_vert_r;
    pos_w_init_s = {1'b0, hstride_r} + {1'b0, pool_horiz_r};
    pos_h_init_s = {1'b0, vstride_r} + {1'b0, pool_vert_r};
    cfg_bad_s    = (data_wid_r == '0) || (data_hei_r == '0) || (data_ch_r == '0) ||
                   (pool_horiz_r == '0) || (pool_vert_r == '0) ||
                   (hstride_r == '0) || (vstride_r == '0) ||
                   (pool_horiz_r > data_wid_r) || (pool_vert_r > data_hei_r) ||
                   ((pool_type_r != DIM_W'(POOL_MAX)) && (pool_type_r != DIM_W'(POOL_AVG)));
    calc_w_go_s  = (pos_w_r <= {1'b0, data_wid_r});
    calc_h_go_s  = (pos_h_r <= {1'b0, data_hei_r});
    load_s       = (state_r == ST_CALC_H) && !calc_h_go_s;
    step_s       = (state_r == ST_RUN) && rd_valid && rd_ready;
  end

  pool_addr_gen #(
    .DIM_W  (DIM_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk          (clk),
    .rst          (rst),
    .load         (load_s),
    .step         (step_s),
    .data_wid     (data_wid_r),
    .pool_horiz   (pool_horiz_r),
    .pool_vert    (pool_vert_r),
    .horiz_stride (hstride_r),
    .out_wid      (output_wid),
    .out_hei      (output_hei),
    .out_ch       (data_ch_r),
    .plane        (plane_r),
    .row_step     (row_step_r),
    .addr         (rd_addr),
    .first        (win_first),
    .last         (win_last),
    .last_elem    (last_elem_s)
  );

  // Sequencer FSM with all control/status outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      data_wid_r   <= '0;
      data_hei_r   <= '0;
      data_ch_r    <= '0;
      pool_type_r  <= '0;
      pool_horiz_r <= '0;
      pool_vert_r  <= '0;
      hstride_r    <= '0;
      vstride_r    <= '0;
      plane_r      <= '0;
      row_step_r   <= '0;
      pos_w_r      <= '0;
      pos_h_r      <= '0;
      rd_valid     <= 1'b0;
      dp_op        <= 1'b0;
      win_size     <= '0;
      output_wid   <= '0;
      output_hei   <= '0;
      output_ch    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            data_wid_r   <= cfg_data_wid;
            data_hei_r   <= cfg_data_hei;
            data_ch_r    <= cfg_data_ch;
            pool_type_r  <= cfg_pool_type;
            pool_horiz_r <= cfg_pool_horiz;
            pool_vert_r  <= cfg_pool_vert;
            hstride_r    <= cfg_horiz_stride;
            vstride_r    <= cfg_vert_stride;
            dp_op        <= cfg_pool_type[0];
            err          <= 1'b0;
            busy         <= 1'b1;
            state_r      <= ST_CHECK;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          output_ch <= '0;
          if (cfg_bad_s) begin
            err        <= 1'b1;
            output_wid <= '0;
            output_hei <= '0;
            win_size   <= '0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state_r    <= ST_DONE;
          end else begin
            plane_r    <= plane_s;
            row_step_r <= row_step_s;
            win_size   <= win_size_s;
            output_wid <= DIM_W'(1'b1);
            output_hei <= DIM_W'(1'b1);
            pos_w_r    <= pos_w_init_s;
            pos_h_r    <= pos_h_init_s;
            state_r    <= ST_CALC_W;
          end
        end
        ST_CALC_W: begin
          // pos_w_r tracks output_wid*horiz_stride + pool_horiz without a multiplier
          if (calc_w_go_s) begin
            output_wid <= output_wid + DIM_W'(1'b1);
            pos_w_r    <= pos_w_r + {1'b0, hstride_r};
          end else begin
            state_r <= ST_CALC_H;
          end
        end
        ST_CALC_H: begin
          if (calc_h_go_s) begin
            output_hei <= output_hei + DIM_W'(1'b1);
            pos_h_r    <= pos_h_r + {1'b0, vstride_r};
          end else begin
            output_ch <= data_ch_r;
            rd_valid  <= 1'b1;
            state_r   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (rd_valid && rd_ready && last_elem_s) begin
            rd_valid <= 1'b0;
            state_r  <= ST_DRAIN;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (dp_idle) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          rd_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pool_sequencer.sv
// Self-checking bench for pool_sequencer: directed and randomized configs
// against a nested-loop reference model, with random read stalls.
module tb_pool_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, rd_ready, dp_idle;
  logic [15:0] cfg_data_wid, cfg_data_hei, cfg_data_ch, cfg_pool_type;
  logic [15:0] cfg_pool_horiz, cfg_pool_vert, cfg_horiz_stride, cfg_vert_stride;
  logic        rd_valid, win_first, win_last, dp_op, busy, done, err;
  logic [15:0] rd_addr, win_size, output_wid, output_hei, output_ch, out_data_wid, out_data_hei;

  always #5 clk = ~clk;

  pool_sequencer #(.ADDR_W(16), .DIM_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_data_wid(cfg_data_wid), .cfg_data_hei(cfg_data_hei), .cfg_data_ch(cfg_data_ch),
    .cfg_pool_type(cfg_pool_type), .cfg_pool_horiz(cfg_pool_horiz), .cfg_pool_vert(cfg_pool_vert),
    .cfg_horiz_stride(cfg_horiz_stride), .cfg_vert_stride(cfg_vert_stride),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .win_first(win_first), .win_last(win_last), .dp_op(dp_op), .win_size(win_size),
    .dp_idle(dp_idle), .output_wid(output_wid), .output_hei(output_hei), .output_ch(output_ch),
    .out_data_wid(out_data_wid), .out_data_hei(out_data_hei),
    .busy(busy), .done(done), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int exp_addr[$];
  bit exp_first[$], exp_last[$];
  int act_addr[$];
  bit act_first[$], act_last[$];
  int exp_ow, exp_oh, exp_oc;
  bit exp_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: output size from the closed-form pooling formula, reads from plain nested loops.
  task automatic model(input int dw, dh, ch, pt, ph, pv, hs, vs);
    exp_addr.delete(); exp_first.delete(); exp_last.delete();
    exp_err = (dw == 0) || (dh == 0) || (ch == 0) || (ph == 0) || (pv == 0) ||
              (hs == 0) || (vs == 0) || (ph > dw) || (pv > dh) || (pt > 1);
    if (exp_err) begin
      exp_ow = 0; exp_oh = 0; exp_oc = 0;
    end else begin
      exp_ow = (dw - ph) / hs + 1;
      exp_oh = (dh - pv) / vs + 1;
      exp_oc = ch;
      for (int c = 0; c < exp_oc; c++)
        for (int oy = 0; oy < exp_oh; oy++)
          for (int ox = 0; ox < exp_ow; ox++)
            for (int ky = 0; ky < pv; ky++)
              for (int kx = 0; kx < ph; kx++) begin
                exp_addr.push_back((c * dw * dh + (oy * vs + ky) * dw + ox * hs + kx) & 16'hFFFF);
                exp_first.push_back((ky == 0) && (kx == 0));
                exp_last.push_back((ky == pv - 1) && (kx == ph - 1));
              end
    end
  endtask

  task automatic run_cfg(input int dw, dh, ch, pt, ph, pv, hs, vs,
                         input int stall_pct, input bit spurious, input string tag);
    int n, extra, done_cnt, first_valid_n, done_n, mism, nmin;
    bit done_seen, prev_stall, expect_low, prev_idle, idle_at_done, busy_at_done;
    logic [15:0] prev_addr;
    logic prev_f, prev_l;
    model(dw, dh, ch, pt, ph, pv, hs, vs);
    act_addr.delete(); act_first.delete(); act_last.delete();
    cfg_data_wid = 16'(dw); cfg_data_hei = 16'(dh); cfg_data_ch = 16'(ch);
    cfg_pool_type = 16'(pt); cfg_pool_horiz = 16'(ph); cfg_pool_vert = 16'(pv);
    cfg_horiz_stride = 16'(hs); cfg_vert_stride = 16'(vs);
    start = 1'b1;
    n = 0; extra = 0; done_cnt = 0; first_valid_n = -1; done_n = -1;
    done_seen = 1'b0; prev_stall = 1'b0; expect_low = 1'b0; prev_idle = dp_idle;
    idle_at_done = 1'b0; busy_at_done = 1'b1;
    prev_addr = '0; prev_f = 1'b0; prev_l = 1'b0;
    while (n < 6000 && !(done_seen && extra >= 3)) begin
      @(negedge clk);
      if (expect_low) begin
        chk({tag, "/valid_low_after_last"}, rd_valid, 0);
        expect_low = 1'b0;
      end
      if (prev_stall) begin
        chk({tag, "/stall_valid"}, rd_valid, 1);
        chk({tag, "/stall_addr"}, rd_addr, prev_addr);
        chk({tag, "/stall_marks"}, {win_first, win_last}, {prev_f, prev_l});
      end
      if (rd_valid && first_valid_n < 0) first_valid_n = n;
      if (rd_valid && rd_ready) begin
        act_addr.push_back(int'(rd_addr));
        act_first.push_back(win_first);
        act_last.push_back(win_last);
        if (act_addr.size() == exp_addr.size()) expect_low = 1'b1;
      end
      prev_stall = rd_valid && !rd_ready;
      prev_addr = rd_addr; prev_f = win_first; prev_l = win_last;
      if (done) begin
        done_cnt++;
        if (!done_seen) begin
          done_n = n; idle_at_done = prev_idle; busy_at_done = busy;
        end
        done_seen = 1'b1;
      end
      if (done_seen) extra++;
      prev_idle = dp_idle;
      @(posedge clk);
      #1;
      start = spurious && busy && ($urandom_range(0, 9) == 0);
      rd_ready = ($urandom_range(0, 99) >= stall_pct);
      dp_idle = ($urandom_range(0, 1) == 1);
      n++;
    end
    start = 1'b0;
    chk({tag, "/done_seen"}, done_seen, 1);
    chk({tag, "/done_pulses"}, done_cnt, 1);
    chk({tag, "/busy_at_done"}, busy_at_done, 0);
    chk({tag, "/err"}, err, exp_err);
    chk({tag, "/output_wid"}, output_wid, exp_ow);
    chk({tag, "/output_hei"}, output_hei, exp_oh);
    chk({tag, "/output_ch"}, output_ch, exp_oc);
    chk({tag, "/out_data_dims"}, {out_data_wid, out_data_hei}, {16'(exp_ow), 16'(exp_oh)});
    chk({tag, "/read_count"}, act_addr.size(), exp_addr.size());
    if (exp_err) begin
      chk({tag, "/err_done_latency"}, done_n, 2);
      chk({tag, "/err_no_valid"}, first_valid_n, -1);
    end else begin
      chk({tag, "/win_size"}, win_size, (ph * pv) & 16'hFFFF);
      chk({tag, "/dp_op"}, dp_op, pt & 1);
      chk({tag, "/start_latency"}, first_valid_n, 2 + exp_ow + exp_oh);
      chk({tag, "/drained_before_done"}, idle_at_done, 1);
      mism = -1;
      nmin = (act_addr.size() < exp_addr.size()) ? act_addr.size() : exp_addr.size();
      for (int i = 0; i < nmin; i++)
        if (mism < 0 && (act_addr[i] != exp_addr[i] || act_first[i] != exp_first[i] ||
                         act_last[i] != exp_last[i])) mism = i;
      if (mism < 0 && act_addr.size() != exp_addr.size()) mism = nmin;
      chk({tag, "/seq_first_bad_index"}, mism, -1);
    end
  endtask

  int t1_exp[16];
  int t2_exp[9];
  int idx_bad;

  initial begin
    rst = 1'b1; start = 1'b0; rd_ready = 1'b1; dp_idle = 1'b0;
    cfg_data_wid = '0; cfg_data_hei = '0; cfg_data_ch = '0; cfg_pool_type = '0;
    cfg_pool_horiz = '0; cfg_pool_vert = '0; cfg_horiz_stride = '0; cfg_vert_stride = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset/ctrl", {busy, done, err, rd_valid, win_first, win_last, dp_op}, 7'd0);
    chk("reset/rd_addr", rd_addr, 0);
    chk("reset/dims", {output_wid, output_hei, output_ch, win_size}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    dp_idle = 1'b1;

    // 4x4x1, 2x2 window, stride 2, max, no stalls
    run_cfg(4, 4, 1, 0, 2, 2, 2, 2, 0, 1'b0, "t1");
    t1_exp = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    idx_bad = -1;
    for (int i = 0; i < 16; i++)
      if (idx_bad < 0 && (i >= act_addr.size() || act_addr[i] != t1_exp[i])) idx_bad = i;
    chk("t1/literal_addr_list", idx_bad, -1);

    // 5x5x1, 3x3 window, stride 1, average
    run_cfg(5, 5, 1, 1, 3, 3, 1, 1, 0, 1'b0, "t2");
    t2_exp = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    idx_bad = -1;
    for (int i = 0; i < 9; i++)
      if (idx_bad < 0 && (i >= act_addr.size() || act_addr[i] != t2_exp[i])) idx_bad = i;
    chk("t2/first_window", idx_bad, -1);

    // two channels: channel 1 starts at plane offset 16
    run_cfg(4, 4, 2, 0, 2, 2, 2, 2, 0, 1'b0, "t3");
    chk("t3/ch1_first_addr", (act_addr.size() > 16) ? act_addr[16] : -1, 16);

    // invalid configurations
    run_cfg(4, 4, 1, 0, 5, 2, 2, 2, 0, 1'b0, "bad_horiz");
    run_cfg(4, 4, 1, 0, 2, 2, 0, 2, 0, 1'b0, "bad_stride");
    run_cfg(4, 4, 1, 2, 2, 2, 2, 2, 0, 1'b0, "bad_type");

    // random stalls and spurious starts while busy
    run_cfg(4, 4, 2, 0, 2, 2, 2, 2, 40, 1'b1, "stall");

    // reset in the middle of RUN, then a clean rerun
    cfg_data_wid = 16'd4; cfg_data_hei = 16'd4; cfg_data_ch = 16'd2; cfg_pool_type = 16'd1;
    cfg_pool_horiz = 16'd2; cfg_pool_vert = 16'd2; cfg_horiz_stride = 16'd2; cfg_vert_stride = 16'd2;
    rd_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("midrst/in_run", rd_valid, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst/ctrl", {busy, rd_valid, done, err, win_first, win_last, dp_op}, 7'd0);
    chk("midrst/addr_dims", {rd_addr, output_wid, output_hei, output_ch}, 64'd0);
    repeat (3) @(negedge clk);
    chk("midrst/no_valid", rd_valid, 0);
    @(posedge clk); #1;
    run_cfg(4, 4, 2, 1, 2, 2, 2, 2, 0, 1'b0, "after_rst");

    // randomized configurations, occasionally invalid
    for (int r = 0; r < 8; r++) begin
      int dw, dh, ch, pt, ph, pv, hs, vs;
      dw = $urandom_range(1, 7); dh = $urandom_range(1, 7); ch = $urandom_range(1, 2);
      pt = $urandom_range(0, 1);
      ph = $urandom_range(1, dw); pv = $urandom_range(1, dh);
      hs = $urandom_range(1, 3); vs = $urandom_range(1, 3);
      case ($urandom_range(0, 7))
        0: ph = dw + 1;
        1: vs = 0;
        2: pt = 3;
        default: ;
      endcase
      run_cfg(dw, dh, ch, pt, ph, pv, hs, vs, 25, 1'b1, $sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
